// File: rtl/affine_nest_counter.sv
// affine_nest_counter: walks a DIMS-deep rectangular loop nest, one iteration
// every II enabled cycles, emitting a valid strobe with the full index vector.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet, idx held at 0
//   RUN   | stepping the nest; valid on every II-th enabled cycle
module affine_nest_counter #(
    parameter int DIMS = 2,
    parameter int W    = 32,
    parameter int II   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIMS*W-1:0]   bounds,
    input  logic                en,
    output logic                valid,
    output logic [DIMS*W-1:0]   idx,
    output logic                last,
    output logic                busy,
    output logic                done
);

    localparam int PW = (II > 1) ? $clog2(II) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DIMS*W-1:0]   bound_q;
    logic [DIMS*W-1:0]   idx_q;
    logic [DIMS*W-1:0]   idx_next;
    logic [PW-1:0]       phase_q;
    logic                done_q;
    logic                any_zero;
    logic                all_top;

    // Detect an empty nest on the incoming bounds, and the final iteration on the latched ones.
    always_comb begin
        any_zero = 1'b0;
        all_top  = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (bounds[d*W +: W] == '0) any_zero = 1'b1;
            if (idx_q[d*W +: W] != bound_q[d*W +: W] - W'(1)) all_top = 1'b0;
        end
    end

    // Odometer step: ripple a carry from level 0 upward, wrapping levels at their top.
    always_comb begin
        logic carry;
        idx_next = idx_q;
        carry    = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            if (carry) begin
                if (idx_q[d*W +: W] == bound_q[d*W +: W] - W'(1)) begin
                    idx_next[d*W +: W] = '0;
                end else begin
                    idx_next[d*W +: W] = idx_q[d*W +: W] + W'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    assign busy  = (state_q == RUN);
    assign valid = busy & en & (phase_q == '0);
    assign last  = valid & all_top;
    assign idx   = idx_q;
    assign done  = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: an empty nest never enters RUN; the last valid returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !any_zero) state_d = RUN;
            RUN:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch bounds on accept, advance phase and indices, pulse done after the nest.
    always_ff @(posedge clk) begin
        if (rst) begin
            bound_q <= '0;
            idx_q   <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    bound_q <= bounds;
                    idx_q   <= '0;
                    phase_q <= '0;
                    done_q  <= any_zero;
                end
            end else begin
                if (en) begin
                    phase_q <= (phase_q == PW'(II - 1)) ? '0 : phase_q + PW'(1);
                end
                if (valid) begin
                    if (last) begin
                        idx_q   <= '0;
                        phase_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_affine_nest_counter.sv
// Bench for affine_nest_counter: three instances (II = 1, 2, 3) share clk/rst.
// Expected iterations and done pulses are queued when a nest is started and
// popped by a negedge monitor as the DUTs produce them.
module tb_affine_nest_counter;

    localparam int W    = 8;
    localparam int DIMS = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [2:0]             start, en, valid, last, busy, done;
    logic [2:0][DIMS*W-1:0] bnd;
    logic [2:0][DIMS*W-1:0] idx_o;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          dut;
        int          cyc;
        logic [15:0] idx;
        logic        last;
    } exp_t;

    typedef struct {
        int dut;
        int cyc;
    } done_t;

    exp_t  sb[$];
    done_t dq[$];

    always #5 clk = ~clk;

    // Cycle number: cycle k spans posedge k to posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    affine_nest_counter #(.DIMS(DIMS), .W(W), .II(1)) u_ii1 (
        .clk(clk), .rst(rst), .start(start[0]), .bounds(bnd[0]), .en(en[0]),
        .valid(valid[0]), .idx(idx_o[0]), .last(last[0]), .busy(busy[0]), .done(done[0])
    );

    affine_nest_counter #(.DIMS(DIMS), .W(W), .II(2)) u_ii2 (
        .clk(clk), .rst(rst), .start(start[1]), .bounds(bnd[1]), .en(en[1]),
        .valid(valid[1]), .idx(idx_o[1]), .last(last[1]), .busy(busy[1]), .done(done[1])
    );

    affine_nest_counter #(.DIMS(DIMS), .W(W), .II(3)) u_ii3 (
        .clk(clk), .rst(rst), .start(start[2]), .bounds(bnd[2]), .en(en[2]),
        .valid(valid[2]), .idx(idx_o[2]), .last(last[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Pop and compare expected iterations / done pulses as the DUTs produce them.
    always @(negedge clk) begin : mon
        exp_t  e;
        done_t dn;
        for (int d = 0; d < 3; d++) begin
            if (valid[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'b0, valid[d]}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("valid_dut", d, e.dut);
                    chk("valid_cycle", cyc, e.cyc);
                    chk("idx", {16'b0, idx_o[d]}, {16'b0, e.idx});
                    chk("last", {31'b0, last[d]}, {31'b0, e.last});
                end
            end else if (last[d] === 1'b1) begin
                chk("last_without_valid", {31'b0, last[d]}, 32'd0);
            end
            if (done[d] === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", {31'b0, done[d]}, 32'd0);
                end else begin
                    dn = dq.pop_front();
                    chk("done_dut", d, dn.dut);
                    chk("done_cycle", cyc, dn.cyc);
                end
            end
        end
    end

    // Reference nest walk: iteration k lands at s+1+k*ii, done one cycle after the last.
    task automatic push_nest(input int d, input int ii, input int s,
                             input int b1, input int b0, input int kmax);
        int    n;
        exp_t  e;
        done_t dn;
        n = b1 * b0;
        for (int k = 0; k < n && k < kmax; k++) begin
            e.dut  = d;
            e.cyc  = s + 1 + k * ii;
            e.idx  = {8'(k / b0), 8'(k % b0)};
            e.last = (k == n - 1);
            sb.push_back(e);
        end
        dn.dut = d;
        if (n == 0) begin
            dn.cyc = s + 1;
            dq.push_back(dn);
        end else if (kmax >= n) begin
            dn.cyc = s + (n - 1) * ii + 2;
            dq.push_back(dn);
        end
    endtask

    task automatic go_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold start for the current cycle; returns one cycle later.
    task automatic kick(input int d, input int b1, input int b0, input int ii, input int kmax);
        bnd[d]   = {8'(b1), 8'(b0)};
        start[d] = 1'b1;
        push_nest(d, ii, cyc, b1, b0, kmax);
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || dq.size() != 0) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_valid", sb.size(), 0);
        chk("drain_done", dq.size(), 0);
        sb.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int   s;
        exp_t e;
        done_t dn;
        start = '0;
        en    = '1;
        bnd   = '0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy",  {31'b0, busy[d]},  32'd0);
            chk("rst_valid", {31'b0, valid[d]}, 32'd0);
            chk("rst_done",  {31'b0, done[d]},  32'd0);
            chk("rst_last",  {31'b0, last[d]},  32'd0);
            chk("rst_idx",   {16'b0, idx_o[d]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2x3 nest, II=1; bounds scrambled after acceptance.
        s = cyc;
        kick(0, 3, 2, 1, 1000);
        bnd[0] = 16'hA5A5;
        chk("t1_busy_first", {31'b0, busy[0]}, 32'd1);
        go_cycle(s + 6);
        chk("t1_busy_end", {31'b0, busy[0]}, 32'd1);
        go_cycle(s + 7);
        chk("t1_busy_done", {31'b0, busy[0]}, 32'd0);
        drain();

        // II=3, four iterations.
        kick(2, 1, 4, 3, 1000);
        drain();

        // II=2 with en low for cycles 2-4: phase freezes.
        s = cyc;
        e.dut = 1; e.cyc = s + 1; e.idx = 16'h0000; e.last = 1'b0; sb.push_back(e);
        e.dut = 1; e.cyc = s + 6; e.idx = 16'h0001; e.last = 1'b0; sb.push_back(e);
        e.dut = 1; e.cyc = s + 8; e.idx = 16'h0002; e.last = 1'b1; sb.push_back(e);
        dn.dut = 1; dn.cyc = s + 9; dq.push_back(dn);
        kick(1, 1, 3, 2, 0);
        go_cycle(s + 2);
        en[1] = 1'b0;
        go_cycle(s + 3);
        chk("t3_stall_idx",   {16'b0, idx_o[1]}, 32'h0001);
        chk("t3_stall_busy",  {31'b0, busy[1]},  32'd1);
        chk("t3_stall_valid", {31'b0, valid[1]}, 32'd0);
        go_cycle(s + 5);
        en[1] = 1'b1;
        drain();

        // Zero bound: done next cycle, never busy.
        kick(0, 0, 5, 1, 1000);
        chk("t4_busy", {31'b0, busy[0]}, 32'd0);
        drain();

        // Back-to-back: second start lands in the done cycle.
        s = cyc;
        kick(0, 1, 2, 1, 1000);
        go_cycle(s + 3);
        kick(0, 1, 1, 1, 1000);
        drain();

        // Reset mid-nest, ignored start during RUN.
        s = cyc;
        kick(0, 4, 4, 1, 5);
        go_cycle(s + 3);
        bnd[0]   = 16'h0000;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        go_cycle(s + 5);
        rst = 1'b1;
        go_cycle(s + 6);
        rst = 1'b0;
        chk("t6_busy",  {31'b0, busy[0]},  32'd0);
        chk("t6_valid", {31'b0, valid[0]}, 32'd0);
        chk("t6_idx",   {16'b0, idx_o[0]}, 32'd0);
        chk("t6_done",  {31'b0, done[0]},  32'd0);
        kick(0, 4, 4, 1, 1000);
        drain();

        // Maximum bound on level 0 forces a wrap at 2^W-1.
        kick(0, 2, 255, 1, 1000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
